bcd_modn_counter: RTL and testbench
===================================

Name: bcd_modn_counter

Overview:
- Parametrised two-digit BCD modulo-N counter; successor to the fixed mod-60 ones/tens counter.
- Used for clock seconds/minutes (N=60), hours (N=24 or 12) and similar fields.
- Adds count enable, validated synchronous preset load, registered wrap pulse, and a combinational terminal-count output for synchronous cascading.
- Optional down-count mode.

Parameters:
- MODULUS, 60, count modulus N; legal range 2..100; value sequence 0..N-1.
- TENS_W, 3, tens-digit width; must hold floor((N-1)/10); max 4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-low reset.
- en  input  1  count enable; one step per clk with en=1.
- ld  input  1  synchronous load request.
- ld_ones  input  4  BCD ones digit to load.
- ld_tens  input  TENS_W  BCD tens digit to load.
- ones  output  4  ones digit, registered.
- tens  output  TENS_W  tens digit, registered.
- car  output  1  registered wrap pulse.
- tc  output  1  combinational terminal count, for cascading the next stage's en.
- load_err  output  1  registered one-cycle pulse on a rejected load.

Behaviour:
- V = tens*10 + ones.
- All state updates on the rising clk edge.
- Priority: reset > ld > en > hold.
- Reset (rst=0 at edge): ones=0, tens=0, car=0, load_err=0, regardless of en/ld.
- Up count (en=1, ld=0):
  - ones<9 and V<N-1: ones+1.
  - ones=9 and V<N-1: ones=0, tens+1.
  - V=N-1: ones=0, tens=0, car=1 on the next cycle.
- car:
  - High for exactly one cycle: the cycle in which outputs first show 0 after a wrap.
  - Low in every other cycle, including after loads and while en=0.
- tc = en & (V==N-1), combinational.
  - Stage k+1 en = stage k tc, giving synchronous cascade with no clock ripple.
- Hold (en=0, ld=0): digits unchanged; car=0; load_err=0.
- Load (ld=1):
  - Valid when ld_ones<=9 and ld_tens*10+ld_ones<N.
  - Valid load: digits take the load value on the edge; car=0; load_err=0; en is ignored that cycle (no count).
  - Invalid load: digits held; car=0; load_err=1 for one cycle.
- Validity checks use full-width arithmetic; no truncation of ld_tens*10.
- Reset mid-operation: reset takes effect on the next edge; any pending car/load_err is cleared.
- Out-of-range V is unreachable. If reached anyway (e.g. X-prop, SEU), the next enabled count step forces V=0 with no car pulse.
- Latency:
  - Count/load to output: 1 clk.
  - Wrap to car: same edge as the 0 value appears.
  - tc: 0 clk.

Optional Feature:
- Macro: BCD_MODN_DOWN_EN.
- Defined:
  - Extra input port dn (1 bit), placed after en.
  - dn=1 counts down:
    - ones>0: ones-1.
    - ones=0 and V>0: ones=9, tens-1.
    - V=0: load N-1 in BCD; car=1 on the next cycle (borrow pulse).
  - tc = en & (dn ? V==0 : V==N-1).
  - dn=0 behaves exactly as up count.
  - Load and reset behaviour unchanged.
- Undefined: no dn port; up-count only; behaviour exactly as above.

Test Plan:
- Reset: hold rst=0 for 2 clk with en=1, ld=1 -> ones=0, tens=0, car=0, load_err=0; release rst -> counts 00,01,...
- N=60, en=1 for 60 clk from 00 -> sequence 00..09,10..59.
  - tc=1 only while V=59.
  - Next edge gives 00 with car=1 for one cycle.
  - 09->10 carries into tens.
- Gating: en toggled 1,0,0,1 from 57 -> 58,58,58,59; car=0 throughout; tc=0 while en=0 at 59.
- Load:
  - ld=1, en=1, ld_tens=5, ld_ones=8 -> 58, no count, car=0.
  - Invalid loads: (6,0), (2,10), (0,15) -> value held, load_err=1 for one cycle each.
- N=24, TENS_W=2 instance: count 22,23 -> 00 with car=1; load (2,4) rejected with load_err=1.
- BCD_MODN_DOWN_EN defined, N=60:
  - dn=1 from 01 -> 00, then 59 with car=1, then 58.
  - tc=1 while V=00 and en=1.
  - dn=1 from 10 -> 09.

Source files
------------

// File: rtl/bcd_modn_counter.sv
// Two-digit BCD modulo-MODULUS counter with enable, validated preset load, wrap pulse and cascade tc.
// Optional down-count mode selected by the BCD_MODN_DOWN_EN macro (adds the dn input).
module bcd_modn_counter #(
  parameter int MODULUS = 60,
  parameter int TENS_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
`ifdef BCD_MODN_DOWN_EN
  input  logic              dn,
`endif
  input  logic              ld,
  input  logic [3:0]        ld_ones,
  input  logic [TENS_W-1:0] ld_tens,
  output logic [3:0]        ones,
  output logic [TENS_W-1:0] tens,
  output logic              car,
  output logic              load_err,
  output logic              tc
);

  localparam logic [7:0]        N8       = 8'(MODULUS);
  localparam logic [7:0]        TOP8     = 8'(MODULUS - 1);
  localparam logic [3:0]        TOP_ONES = 4'((MODULUS - 1) % 10);
  localparam logic [TENS_W-1:0] TOP_TENS = TENS_W'((MODULUS - 1) / 10);

  logic       down;
  logic [7:0] v, ld_v;
  logic       bad, ld_ok, at_top, at_zero;

`ifdef BCD_MODN_DOWN_EN
  assign down = dn;
`else
  assign down = 1'b0;
`endif

  // 8-bit arithmetic holds 15*10+15, so ld_tens*10 can never truncate
  assign v       = 8'(tens) * 8'd10 + 8'(ones);
  assign ld_v    = 8'(ld_tens) * 8'd10 + 8'(ld_ones);
  assign ld_ok   = (ld_ones <= 4'd9) && (ld_v < N8);
  assign bad     = (ones > 4'd9) || (v >= N8);
  assign at_top  = (v == TOP8);
  assign at_zero = (v == 8'd0);
  assign tc      = en & (down ? at_zero : at_top);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ones     <= '0;
      tens     <= '0;
      car      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      car      <= 1'b0;
      load_err <= 1'b0;
      if (ld) begin
        if (ld_ok) begin
          ones <= ld_ones;
          tens <= ld_tens;
        end else begin
          load_err <= 1'b1;
        end
      end else if (en) begin
        if (bad) begin
          // corrupted state recovers to zero silently
          ones <= '0;
          tens <= '0;
        end else if (down) begin
          if (at_zero) begin
            ones <= TOP_ONES;
            tens <= TOP_TENS;
            car  <= 1'b1;
          end else if (ones == 4'd0) begin
            ones <= 4'd9;
            tens <= tens - TENS_W'(1);
          end else begin
            ones <= ones - 4'd1;
          end
        end else begin
          if (at_top) begin
            ones <= '0;
            tens <= '0;
            car  <= 1'b1;
          end else if (ones == 4'd9) begin
            ones <= '0;
            tens <= tens + TENS_W'(1);
          end else begin
            ones <= ones + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_modn_counter.sv
// Directed bench for bcd_modn_counter: mod-60 and mod-24 instances, down mode when BCD_MODN_DOWN_EN is set.
module tb_bcd_modn_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // mod-60 instance
  logic       a_rst = 1'b0, a_en = 1'b0, a_ld = 1'b0;
  logic [3:0] a_lo = '0;
  logic [2:0] a_lt = '0;
  logic [3:0] a_ones;
  logic [2:0] a_tens;
  logic       a_car, a_lerr, a_tc;
`ifdef BCD_MODN_DOWN_EN
  logic       a_dn = 1'b0;
`endif

  bcd_modn_counter #(.MODULUS(60), .TENS_W(3)) u_a (
    .clk(clk), .rst(a_rst), .en(a_en),
`ifdef BCD_MODN_DOWN_EN
    .dn(a_dn),
`endif
    .ld(a_ld), .ld_ones(a_lo), .ld_tens(a_lt),
    .ones(a_ones), .tens(a_tens), .car(a_car), .load_err(a_lerr), .tc(a_tc));

  // mod-24 instance
  logic       b_rst = 1'b0, b_en = 1'b0, b_ld = 1'b0;
  logic [3:0] b_lo = '0;
  logic [1:0] b_lt = '0;
  logic [3:0] b_ones;
  logic [1:0] b_tens;
  logic       b_car, b_lerr, b_tc;
`ifdef BCD_MODN_DOWN_EN
  logic       b_dn = 1'b0;
`endif

  bcd_modn_counter #(.MODULUS(24), .TENS_W(2)) u_b (
    .clk(clk), .rst(b_rst), .en(b_en),
`ifdef BCD_MODN_DOWN_EN
    .dn(b_dn),
`endif
    .ld(b_ld), .ld_ones(b_lo), .ld_tens(b_lt),
    .ones(b_ones), .tens(b_tens), .car(b_car), .load_err(b_lerr), .tc(b_tc));

  function automatic int a_val();
    return int'(a_tens) * 10 + int'(a_ones);
  endfunction
  function automatic int b_val();
    return int'(b_tens) * 10 + int'(b_ones);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset dominates en and ld
    #1;
    a_en = 1'b1; a_ld = 1'b1; a_lt = 3'd5; a_lo = 4'd8;
    tick(); tick();
    chk("rst_val", a_val(), 0);
    chk("rst_car", int'(a_car), 0);
    chk("rst_lerr", int'(a_lerr), 0);
    a_rst = 1'b1; a_ld = 1'b0;
    tick(); chk("rel_01", a_val(), 1);
    tick(); chk("rel_02", a_val(), 2);

    // full mod-60 cycle from 00
    a_ld = 1'b1; a_lt = 3'd0; a_lo = 4'd0;
    tick(); chk("ld_00", a_val(), 0);
    a_ld = 1'b0;
    for (int i = 1; i < 60; i++) begin
      tick();
      chk($sformatf("seq_%0d", i), a_val(), i);
      chk($sformatf("seq_car_%0d", i), int'(a_car), 0);
      chk($sformatf("seq_tc_%0d", i), int'(a_tc), (i == 59) ? 1 : 0);
    end
    tick();
    chk("wrap_val", a_val(), 0);
    chk("wrap_car", int'(a_car), 1);
    chk("wrap_tc", int'(a_tc), 0);
    tick();
    chk("post_wrap_val", a_val(), 1);
    chk("post_wrap_car", int'(a_car), 0);

    // enable gating from 57
    a_ld = 1'b1; a_lt = 3'd5; a_lo = 4'd7;
    tick(); chk("ld_57", a_val(), 57);
    a_ld = 1'b0;
    a_en = 1'b1; tick(); chk("gate_58a", a_val(), 58); chk("gate_car_a", int'(a_car), 0);
    a_en = 1'b0; tick(); chk("gate_58b", a_val(), 58); chk("gate_car_b", int'(a_car), 0);
    tick(); chk("gate_58c", a_val(), 58); chk("gate_car_c", int'(a_car), 0);
    a_en = 1'b1; tick(); chk("gate_59", a_val(), 59); chk("gate_car_d", int'(a_car), 0);
    a_en = 1'b0; #1; chk("tc_en0_59", int'(a_tc), 0);
    a_en = 1'b1; #1; chk("tc_en1_59", int'(a_tc), 1);

    // load beats count at terminal value: no wrap, no car
    a_ld = 1'b1; a_lt = 3'd5; a_lo = 4'd8;
    tick();
    chk("ld_58", a_val(), 58);
    chk("ld_58_car", int'(a_car), 0);
    chk("ld_58_lerr", int'(a_lerr), 0);

    // rejected loads hold value and pulse load_err
    a_lt = 3'd6; a_lo = 4'd0;
    tick(); chk("bad60_val", a_val(), 58); chk("bad60_lerr", int'(a_lerr), 1);
    a_ld = 1'b0; a_en = 1'b0;
    tick(); chk("bad60_clr", int'(a_lerr), 0); chk("hold_val", a_val(), 58);
    a_ld = 1'b1; a_lt = 3'd2; a_lo = 4'd10;
    tick(); chk("bad2a_val", a_val(), 58); chk("bad2a_lerr", int'(a_lerr), 1);
    a_ld = 1'b0;
    tick(); chk("bad2a_clr", int'(a_lerr), 0);
    a_ld = 1'b1; a_lt = 3'd0; a_lo = 4'd15;
    tick(); chk("bad0f_val", a_val(), 58); chk("bad0f_lerr", int'(a_lerr), 1);
    a_ld = 1'b0;
    tick(); chk("bad0f_clr", int'(a_lerr), 0);
    a_ld = 1'b1; a_lt = 3'd7; a_lo = 4'd9;
    tick(); chk("bad79_lerr", int'(a_lerr), 1);

    // reset mid-operation clears pending car
    a_lt = 3'd5; a_lo = 4'd9;
    tick(); chk("ld_59", a_val(), 59);
    a_ld = 1'b0; a_en = 1'b1;
    tick(); chk("wrap2_car", int'(a_car), 1);
    a_rst = 1'b0;
    tick(); chk("rst_mid_car", int'(a_car), 0); chk("rst_mid_val", a_val(), 0);
    a_rst = 1'b1; a_en = 1'b0;
    tick();

    // mod-24 instance
    b_rst = 1'b1; b_ld = 1'b1; b_lt = 2'd2; b_lo = 4'd2;
    tick(); chk("b_ld_22", b_val(), 22);
    b_ld = 1'b0; b_en = 1'b1;
    tick(); chk("b_23", b_val(), 23); chk("b_tc_23", int'(b_tc), 1);
    tick(); chk("b_wrap", b_val(), 0); chk("b_wrap_car", int'(b_car), 1);
    b_en = 1'b0; b_ld = 1'b1; b_lt = 2'd2; b_lo = 4'd4;
    tick(); chk("b_bad24_val", b_val(), 0); chk("b_bad24_lerr", int'(b_lerr), 1);
    chk("b_car_clr", int'(b_car), 0);
    b_lo = 4'd3;
    tick(); chk("b_ld_23", b_val(), 23); chk("b_ld_23_lerr", int'(b_lerr), 0);
    b_ld = 1'b0;

`ifdef BCD_MODN_DOWN_EN
    a_ld = 1'b1; a_lt = 3'd0; a_lo = 4'd1;
    tick(); chk("dn_ld_01", a_val(), 1);
    a_ld = 1'b0; a_en = 1'b1; a_dn = 1'b1;
    #1; chk("dn_tc_01", int'(a_tc), 0);
    tick(); chk("dn_00", a_val(), 0); chk("dn_tc_00", int'(a_tc), 1);
    tick(); chk("dn_59", a_val(), 59); chk("dn_car_59", int'(a_car), 1);
    tick(); chk("dn_58", a_val(), 58); chk("dn_car_58", int'(a_car), 0);
    a_ld = 1'b1; a_lt = 3'd1; a_lo = 4'd0;
    tick(); chk("dn_ld_10", a_val(), 10);
    a_ld = 1'b0;
    tick(); chk("dn_09", a_val(), 9);
    a_dn = 1'b0;
    tick(); chk("dn0_up_10", a_val(), 10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
